// File: rtl/mouse_report_parser_if.sv
// ----------------------------------------------------------------------------
// mouse_report_parser_if
// Byte-stream handshake between the USB host byte source and the mouse
// report parser.
//   Byte_In    : report byte driven by the host stream (master -> slave)
//   Byte_Valid : Byte_In is valid this cycle         (master -> slave)
//   Byte_Ready : the parser accepts Byte_In          (slave  -> master)
// A byte transfers on a cycle where Byte_Valid and Byte_Ready are both high.
// The master holds Byte_In stable while Byte_Valid && !Byte_Ready.
// ----------------------------------------------------------------------------
interface mouse_report_parser_if;
    logic [7:0] Byte_In;
    logic       Byte_Valid;
    logic       Byte_Ready;

    modport master (
        output Byte_In,
        output Byte_Valid,
        input  Byte_Ready
    );

    modport slave (
        input  Byte_In,
        input  Byte_Valid,
        output Byte_Ready
    );
endinterface

// File: rtl/mouse_report_parser.sv
// ----------------------------------------------------------------------------
// mouse_report_parser
// Reassembles boot-protocol mouse reports from a host byte stream, accumulates
// X/Y motion with saturation over one video frame, and on every Frame_Tick
// commits one signed 8-bit delta pair plus button state for the cursor logic.
//
// Ports:
//   frame_clk    in   clock
//   Reset        in   synchronous, active-high reset
//   byte_if      slave modport of mouse_report_parser_if (Byte_In/Valid/Ready)
//   Frame_Tick   in   single-cycle frame boundary pulse
//   Mouse_XDiff  out  signed X delta of the frame just ended
//   Mouse_YDiff  out  signed Y delta of the frame just ended (positive = down)
//   Mouse_Wheel  out  signed wheel delta (only with MOUSE_WHEEL_EN)
//   Buttons      out  {5'b0, M, R, L}
//   Delta_Valid  out  one-cycle pulse: at least one report in the frame
//   Delta_Sat    out  saturation occurred in the frame; held until next tick
//   Sync_Err     out  one-cycle pulse when a partial report times out
//
// Optional feature macro: MOUSE_WHEEL_EN
//   defined   : 4-byte reports (btn, X, Y, wheel) and a Mouse_Wheel output
//   undefined : 3-byte reports (btn, X, Y)
// ----------------------------------------------------------------------------
module mouse_report_parser #(
    parameter int GAP_TIMEOUT = 64,
    parameter int DELTA_MAX   = 127
) (
    input  logic                        frame_clk,
    input  logic                        Reset,
    mouse_report_parser_if.slave        byte_if,
    input  logic                        Frame_Tick,
    output logic [7:0]                  Mouse_XDiff,
    output logic [7:0]                  Mouse_YDiff,
`ifdef MOUSE_WHEEL_EN
    output logic [7:0]                  Mouse_Wheel,
`endif
    output logic [7:0]                  Buttons,
    output logic                        Delta_Valid,
    output logic                        Delta_Sat,
    output logic                        Sync_Err
);

    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam logic signed [9:0] LIM_HI = 10'(DELTA_MAX);
    localparam logic signed [9:0] LIM_LO = 10'(-DELTA_MAX - 1);
    localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_BTN = 2'd0,
        S_X   = 2'd1,
        S_Y   = 2'd2,
        S_W   = 2'd3
    } state_t;

    // Saturating add of two signed bytes in 10-bit arithmetic.
    // Returns {saturated, clamped_result[7:0]}.
    function automatic logic [8:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic signed [9:0] sum;
        logic [8:0]        res;
        sum = $signed({{2{a[7]}}, a}) + $signed({{2{b[7]}}, b});
        if (sum > LIM_HI) begin
            res = {1'b1, LIM_HI[7:0]};
        end else if (sum < LIM_LO) begin
            res = {1'b1, LIM_LO[7:0]};
        end else begin
            res = {1'b0, sum[7:0]};
        end
        return res;
    endfunction

    state_t        state_q;
    logic [GW-1:0] gap_q;
    logic [7:0]    btn_tmp_q;
    logic [7:0]    x_tmp_q;
    logic [7:0]    acc_x_q;
    logic [7:0]    acc_y_q;
    logic [2:0]    press_q;
    logic [2:0]    last_btn_q;
    logic          sat_flag_q;
    logic          got_report_q;

    logic          xfer_s;
    logic [8:0]    sum_x_d;
    logic [8:0]    sum_y_d;
    logic [7:0]    y_src_s;

`ifdef MOUSE_WHEEL_EN
    logic [7:0]    y_tmp_q;
    logic [7:0]    acc_w_q;
    logic [8:0]    sum_w_d;
`endif

    // No byte is consumed on a commit cycle, so a report never completes
    // in the same cycle the accumulators are being cleared.
    assign byte_if.Byte_Ready = !Frame_Tick;
    assign xfer_s             = byte_if.Byte_Valid && !Frame_Tick;

`ifdef MOUSE_WHEEL_EN
    assign y_src_s = y_tmp_q;
    assign sum_w_d = sat_add(acc_w_q, byte_if.Byte_In);
`else
    assign y_src_s = byte_if.Byte_In;
`endif

    assign sum_x_d = sat_add(acc_x_q, x_tmp_q);
    assign sum_y_d = sat_add(acc_y_q, y_src_s);

    // Report FSM, gap timer, frame accumulators and registered outputs.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= S_BTN;
            gap_q        <= '0;
            btn_tmp_q    <= 8'h00;
            x_tmp_q      <= 8'h00;
            acc_x_q      <= 8'h00;
            acc_y_q      <= 8'h00;
            press_q      <= 3'b000;
            last_btn_q   <= 3'b000;
            sat_flag_q   <= 1'b0;
            got_report_q <= 1'b0;
            Mouse_XDiff  <= 8'h00;
            Mouse_YDiff  <= 8'h00;
            Buttons      <= 8'h00;
            Delta_Valid  <= 1'b0;
            Delta_Sat    <= 1'b0;
            Sync_Err     <= 1'b0;
`ifdef MOUSE_WHEEL_EN
            y_tmp_q      <= 8'h00;
            acc_w_q      <= 8'h00;
            Mouse_Wheel  <= 8'h00;
`endif
        end else begin
            Delta_Valid <= 1'b0;
            Sync_Err    <= 1'b0;

            // Commit the frame; last_btn_q is kept so held buttons persist.
            if (Frame_Tick) begin
                Mouse_XDiff  <= acc_x_q;
                Mouse_YDiff  <= acc_y_q;
                Buttons      <= {5'b00000, last_btn_q | press_q};
                Delta_Valid  <= got_report_q;
                Delta_Sat    <= sat_flag_q;
                acc_x_q      <= 8'h00;
                acc_y_q      <= 8'h00;
                press_q      <= 3'b000;
                sat_flag_q   <= 1'b0;
                got_report_q <= 1'b0;
`ifdef MOUSE_WHEEL_EN
                Mouse_Wheel  <= acc_w_q;
                acc_w_q      <= 8'h00;
`endif
            end else begin
                Delta_Valid <= 1'b0;
            end

            case (state_q)
                S_BTN: begin
                    gap_q <= '0;
                    if (xfer_s) begin
                        btn_tmp_q <= byte_if.Byte_In;
                        state_q   <= S_X;
                    end else begin
                        state_q   <= S_BTN;
                    end
                end
                S_X, S_Y, S_W: begin
                    if (xfer_s) begin
                        gap_q <= '0;
                        if (state_q == S_X) begin
                            x_tmp_q <= byte_if.Byte_In;
                            state_q <= S_Y;
`ifdef MOUSE_WHEEL_EN
                        end else if (state_q == S_Y) begin
                            y_tmp_q <= byte_if.Byte_In;
                            state_q <= S_W;
`endif
                        end else begin
                            // Final byte of the report: fold it into the frame.
                            acc_x_q      <= sum_x_d[7:0];
                            acc_y_q      <= sum_y_d[7:0];
`ifdef MOUSE_WHEEL_EN
                            acc_w_q      <= sum_w_d[7:0];
                            sat_flag_q   <= sat_flag_q | sum_x_d[8] | sum_y_d[8] | sum_w_d[8];
`else
                            sat_flag_q   <= sat_flag_q | sum_x_d[8] | sum_y_d[8];
`endif
                            press_q      <= press_q | btn_tmp_q[2:0];
                            last_btn_q   <= btn_tmp_q[2:0];
                            got_report_q <= 1'b1;
                            state_q      <= S_BTN;
                        end
                    end else if (gap_q == GAP_LAST) begin
                        // Host went quiet mid-report: drop the partial report.
                        gap_q    <= '0;
                        state_q  <= S_BTN;
                        Sync_Err <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: begin
                    gap_q   <= '0;
                    state_q <= S_BTN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_report_parser.sv
module tb_mouse_report_parser;

    logic       frame_clk;
    logic       Reset;
    logic       Frame_Tick;
    logic [7:0] Mouse_XDiff;
    logic [7:0] Mouse_YDiff;
    logic [7:0] Buttons;
    logic       Delta_Valid;
    logic       Delta_Sat;
    logic       Sync_Err;
`ifdef MOUSE_WHEEL_EN
    logic [7:0] Mouse_Wheel;
`endif

    int total;
    int bad;
    bit seen;

    mouse_report_parser_if bif ();

    mouse_report_parser dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .byte_if     (bif.slave),
        .Frame_Tick  (Frame_Tick),
        .Mouse_XDiff (Mouse_XDiff),
        .Mouse_YDiff (Mouse_YDiff),
`ifdef MOUSE_WHEEL_EN
        .Mouse_Wheel (Mouse_Wheel),
`endif
        .Buttons     (Buttons),
        .Delta_Valid (Delta_Valid),
        .Delta_Sat   (Delta_Sat),
        .Sync_Err    (Sync_Err)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bif.Byte_Valid = 1'b1;
        bif.Byte_In    = b;
        step();
        bif.Byte_Valid = 1'b0;
        bif.Byte_In    = 8'h00;
    endtask

    // Bytes after the button byte; wheel builds get a zero wheel byte.
    task automatic send_tail(input logic [7:0] x, input logic [7:0] y);
        send_byte(x);
        send_byte(y);
`ifdef MOUSE_WHEEL_EN
        send_byte(8'h00);
`endif
    endtask

    task automatic send_report(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y);
        send_byte(b);
        send_tail(x, y);
    endtask

    task automatic tick();
        Frame_Tick = 1'b1;
        step();
        Frame_Tick = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        Reset          = 1'b1;
        Frame_Tick     = 1'b0;
        bif.Byte_Valid = 1'b0;
        bif.Byte_In    = 8'h00;
        step();
        step();

        // Reset values
        chk("rst_x",     Mouse_XDiff, 8'h00);
        chk("rst_btn",   Buttons, 8'h00);
        chk("rst_dv",    {7'd0, Delta_Valid}, 8'h00);
        chk("rst_sat",   {7'd0, Delta_Sat}, 8'h00);
        chk("rst_ready", {7'd0, bif.Byte_Ready}, 8'h01);
        Reset = 1'b0;
        step();

        // Basic report
        send_report(8'h01, 8'h05, 8'hFD);
        step();
        tick();
        chk("basic_x",   Mouse_XDiff, 8'h05);
        chk("basic_y",   Mouse_YDiff, 8'hFD);
        chk("basic_btn", Buttons, 8'h01);
        chk("basic_dv",  {7'd0, Delta_Valid}, 8'h01);
        chk("basic_sat", {7'd0, Delta_Sat}, 8'h00);
        step();
        chk("basic_dv_pulse", {7'd0, Delta_Valid}, 8'h00);
        chk("basic_x_hold",   Mouse_XDiff, 8'h05);

        // Positive saturation
        for (int i = 0; i < 3; i++) send_report(8'h00, 8'h64, 8'h00);
        tick();
        chk("satp_x",   Mouse_XDiff, 8'h7F);
        chk("satp_sat", {7'd0, Delta_Sat}, 8'h01);
        chk("satp_btn", Buttons, 8'h00);

        // Negative saturation
        for (int i = 0; i < 3; i++) send_report(8'h00, 8'h9C, 8'h00);
        tick();
        chk("satn_x",   Mouse_XDiff, 8'h80);
        chk("satn_sat", {7'd0, Delta_Sat}, 8'h01);

        // Gap timeout on a partial report
        send_byte(8'h02);
        send_byte(8'h10);
        for (int i = 0; i < 60; i++) step();
        chk("gap_early", {7'd0, Sync_Err}, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (Sync_Err) seen = 1'b1;
        end
        chk("gap_seen", {7'd0, seen}, 8'h01);
        step();
        chk("gap_pulse", {7'd0, Sync_Err}, 8'h00);
        send_report(8'h00, 8'h01, 8'h01);
        tick();
        chk("resync_x",   Mouse_XDiff, 8'h01);
        chk("resync_y",   Mouse_YDiff, 8'h01);
        chk("resync_btn", Buttons, 8'h00);
        chk("resync_sat", {7'd0, Delta_Sat}, 8'h00);

        // Press capture, then empty frame
        send_report(8'h04, 8'h00, 8'h00);
        send_report(8'h00, 8'h00, 8'h00);
        tick();
        chk("press_btn", Buttons, 8'h04);
        chk("press_dv",  {7'd0, Delta_Valid}, 8'h01);
        step();
        tick();
        chk("empty_btn", Buttons, 8'h00);
        chk("empty_dv",  {7'd0, Delta_Valid}, 8'h00);
        chk("empty_x",   Mouse_XDiff, 8'h00);

        // Byte held valid across a tick
        bif.Byte_Valid = 1'b1;
        bif.Byte_In    = 8'h02;
        Frame_Tick     = 1'b1;
        #1;
        chk("stall_ready", {7'd0, bif.Byte_Ready}, 8'h00);
        step();
        Frame_Tick = 1'b0;
        #1;
        chk("stall_dv",    {7'd0, Delta_Valid}, 8'h00);
        chk("stall_ready2", {7'd0, bif.Byte_Ready}, 8'h01);
        step();
        bif.Byte_Valid = 1'b0;
        send_tail(8'h03, 8'h04);
        tick();
        chk("stall_x",   Mouse_XDiff, 8'h03);
        chk("stall_y",   Mouse_YDiff, 8'h04);
        chk("stall_btn", Buttons, 8'h02);
        chk("stall_dv2", {7'd0, Delta_Valid}, 8'h01);

        // Reset mid-report
        send_byte(8'h01);
        send_byte(8'h7F);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mrst_err", {7'd0, Sync_Err}, 8'h00);
        chk("mrst_x",   Mouse_XDiff, 8'h00);
        send_report(8'h00, 8'h02, 8'h02);
        tick();
        chk("mrst_x2",  Mouse_XDiff, 8'h02);
        chk("mrst_y2",  Mouse_YDiff, 8'h02);
        chk("mrst_btn", Buttons, 8'h00);

`ifdef MOUSE_WHEEL_EN
        // Wheel accumulation
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hFF);
        tick();
        chk("wheel_w",  Mouse_Wheel, 8'hFF);
        chk("wheel_x",  Mouse_XDiff, 8'h00);
        chk("wheel_dv", {7'd0, Delta_Valid}, 8'h01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mouse_report_parser.md
Name: mouse_report_parser

Overview:
- Producer side of the cursor-delta interface.
- Consumes raw boot-protocol mouse report bytes from the USB host byte stream (valid/ready handshake).
- Reassembles reports and accumulates X/Y motion with saturation across one video frame.
- On each frame boundary, presents one signed 8-bit delta pair plus button state to the cursor-position logic.

Parameters:
- GAP_TIMEOUT, 64, idle cycles allowed between bytes of one report before the partial report is discarded.
- DELTA_MAX, 127, positive saturation limit of the per-frame delta; the negative limit is -(DELTA_MAX+1).

Ports:
- frame_clk  in  1  clock.
- Reset  in  1  reset; synchronous, active-high.
- Byte_In  in  8  report byte from the host stream.
- Byte_Valid  in  1  Byte_In is valid this cycle.
- Byte_Ready  out  1  the block accepts Byte_In this cycle.
- Frame_Tick  in  1  single-cycle pulse marking the frame boundary.
- Mouse_XDiff  out  8  signed X delta for the frame just ended.
- Mouse_YDiff  out  8  signed Y delta for the frame just ended.
- Buttons  out  8  bits[2:0] are L/R/M, bits[7:3] are 0.
- Delta_Valid  out  1  one-cycle pulse; at least one report arrived in the frame just ended.
- Delta_Sat  out  1  saturation occurred in the frame just ended; held until the next tick.
- Sync_Err  out  1  one-cycle pulse when a partial report is discarded on timeout.

Behaviour:
- Reset: all outputs 0, except Byte_Ready = 1.
  - FSM to S_BTN; accumulators, gap counter and press-capture register cleared.
- Handshake:
  - A byte transfers on a cycle with Byte_Valid and Byte_Ready both high.
  - Byte_Ready = !Frame_Tick (combinational), so no byte is consumed on a commit cycle.
  - The upstream holds Byte_In while Byte_Valid && !Byte_Ready.
- FSM states S_BTN -> S_X -> S_Y -> S_BTN; each state advances on one transfer.
  - S_BTN stores the byte into a temporary button register.
  - S_X stores the X byte (signed).
  - S_Y completes the report in the same cycle:
    - acc_x += X and acc_y += Y, using 10-bit signed arithmetic.
    - Each sum is clamped to [-(DELTA_MAX+1), DELTA_MAX]; if the clamp engages, set sat_flag.
    - press |= btn[2:0].
    - last_btn <= btn[2:0].
    - got_report <= 1.
- Y passes through unmodified (positive = down). The consumer scales and clamps position.
- Gap timer:
  - Counts idle cycles while the FSM is in S_X or S_Y; reset on every transfer.
  - When the count reaches GAP_TIMEOUT, the partial report is dropped, the FSM returns to S_BTN and Sync_Err pulses; accumulators are untouched.
  - The timer is held at 0 in S_BTN.
- Frame_Tick (commit), registered with 1-cycle latency:
  - Mouse_XDiff <= acc_x, Mouse_YDiff <= acc_y.
  - Buttons <= {5'b0, last_btn | press}.
  - Delta_Valid <= got_report for exactly one cycle.
  - Delta_Sat <= sat_flag.
  - Then acc_x, acc_y, press, sat_flag and got_report clear to 0.
  - last_btn is retained, so held buttons persist across empty frames.
- Frame with no reports: XDiff = YDiff = 0, Buttons = last_btn, Delta_Valid = 0.
- A tick arriving mid-report does not reset the FSM; the remaining bytes complete into the next frame.
- Reset mid-report: the partial report is discarded and no Sync_Err is raised.
- Outputs hold stable between ticks.

Optional Feature:
- Macro: MOUSE_WHEEL_EN.
- Defined:
  - Reports are 4 bytes; an S_W state follows S_Y and completes the report.
  - Wheel accumulates with the same clamp.
  - Extra output Mouse_Wheel (out, 8, signed) is committed on tick like X/Y and included in Delta_Sat.
  - The gap timer also runs in S_Y/S_W.
- Not defined:
  - 3-byte reports; no Mouse_Wheel port; S_Y completes the report.

Test Plan:
- Reset, then send bytes 01,05,FD, then Frame_Tick → next cycle XDiff=05, YDiff=FD (-3), Buttons=01, Delta_Valid=1 for one cycle, Delta_Sat=0.
- Three reports of X=+100 in one frame, then tick → XDiff=7F, Delta_Sat=1. Three reports of X=-100 → XDiff=80.
- Send 02,10, then idle GAP_TIMEOUT cycles → Sync_Err pulse. Then send 00,01,01 plus tick → XDiff=01, YDiff=01, Buttons=00.
- Report with btn=04, then report with btn=00, then tick → Buttons=04. Next tick with no reports → Buttons=00, Delta_Valid=0, XDiff=00.
- Byte_Valid held high across a Frame_Tick → Byte_Ready=0 on that cycle, the byte is accepted the following cycle, and no byte is lost or duplicated.
- MOUSE_WHEEL_EN: bytes 00,00,00,FF then tick → Mouse_Wheel=FF. Reset asserted after 2 bytes → the next 4-byte report parses correctly.
